// File: rtl/rd_req_arbiter.sv
// Four-port round-robin arbiter for downstream burst reads.
// Tracks per-port outstanding bursts and flags protocol errors on a sticky err bit.
module rd_req_arbiter #(
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned NUM_PORTS       = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [3:0]   req_i,
   input  logic [31:0]  len_i,
   input  logic [255:0] addr_i,
   output logic [3:0]   ack_o,
   output logic         rd_req,
   output logic [7:0]   rd_len,
   output logic [63:0]  rd_address,
   output logic [1:0]   rd_id,
   input  logic         rd_req_ack,
   input  logic         rd_done,
   input  logic [1:0]   rd_done_id,
   output logic         busy,
   output logic         err
);

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

   state_t      state_q, state_d;
   logic [1:0]  grant_q, grant_d;
   logic [1:0]  ptr_q, ptr_d;
   logic [3:0]  cnt_q [NUM_PORTS];
   logic [3:0]  cnt_d [NUM_PORTS];
   logic        err_q, err_d;
   logic        accept;
   logic [3:0]  eligible;
   logic        found;
   logic [1:0]  winner;
   logic [1:0]  idx;
   logic        underflow;

   // Reset gates the request/ack outputs so nothing leaks out during a reset cycle.
   assign rd_req     = (state_q == GRANT) && req_i[grant_q] && !rst;
   assign rd_len     = len_i[{grant_q, 3'b000} +: 8];
   assign rd_address = addr_i[{grant_q, 6'b000000} +: 64];
   assign rd_id      = grant_q;
   assign err        = err_q;

   always_comb begin
      busy = (state_q == GRANT);
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         busy = busy | (cnt_q[i] != '0);
      end
      busy = busy && !rst;
   end

   always_comb begin
      eligible = '0;
      found    = 1'b0;
      winner   = ptr_q;
      idx      = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         eligible[i] = req_i[i] && (cnt_q[i] < MAX_CNT);
      end
      // Search ascending from ptr, wrapping 3 -> 0.
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         idx = ptr_q + 2'(i);
         if (!found && eligible[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      ack_o   = '0;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (found) begin
               grant_d = winner;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (!req_i[grant_q]) begin
               state_d = IDLE;
            end else if (rd_req_ack && !rst) begin
               accept         = 1'b1;
               ack_o[grant_q] = 1'b1;
               ptr_d          = grant_q + 2'd1;
               state_d        = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      underflow = 1'b0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (accept && (grant_q == 2'(i)) && !(rd_done && (rd_done_id == 2'(i)))) begin
            cnt_d[i] = cnt_q[i] + 4'd1;
         end else if (rd_done && (rd_done_id == 2'(i)) && !(accept && (grant_q == 2'(i)))) begin
            if (cnt_q[i] == '0) begin
               underflow = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] - 4'd1;
            end
         end
      end
      err_d = err_q | underflow | (rd_req_ack && !rd_req);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         err_q   <= 1'b0;
         for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         err_q   <= err_d;
         for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

endmodule

// File: doc/rd_req_arbiter.md
RD_REQ_ARBITER -- requirements
Module: rd_req_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, meaning the maximum number of accepted, not-yet-completed bursts per port (range 1..15).
REQ-002 SHALL have parameter NUM_PORTS, default 4, fixed at 4; port index width 2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req_i  input  4  per-port burst-read request, held high until acked.
REQ-006 len_i  input  4x8  per-port burst length minus one (beats of 64B).
REQ-007 addr_i  input  4x64  per-port burst start byte address.
REQ-008 ack_o  output  4  per-port one-cycle accept pulse.
REQ-009 rd_req  output  1  downstream read request.
REQ-010 rd_len  output  8  downstream burst length minus one.
REQ-011 rd_address  output  64  downstream burst address.
REQ-012 rd_id  output  2  index of the port owning the current rd_req.
REQ-013 rd_req_ack  input  1  downstream accept; valid only while rd_req=1.
REQ-014 rd_done  input  1  one-cycle pulse: a burst fully returned.
REQ-015 rd_done_id  input  2  port index for rd_done.
REQ-016 busy  output  1  high when any outstanding count is non-zero or state is GRANT.
REQ-017 err  output  1  sticky protocol error flag.

Function
REQ-018 SHALL implement a two-state FSM: IDLE, GRANT.
REQ-019 In IDLE, eligible port = req_i[p]=1 and outstanding[p] < MAX_OUTSTANDING; round-robin search starts at pointer ptr, ascending, wrapping 3->0.
REQ-020 In IDLE with at least one eligible port: register grant=winner, rd_id=winner, go to GRANT next cycle; with none eligible: stay in IDLE.
REQ-021 rd_req SHALL be (state==GRANT) && req_i[grant]; rd_len/rd_address SHALL be len_i[grant]/addr_i[grant] combinationally.
REQ-022 Arbitration latency: first rd_req assertion exactly 1 cycle after req_i rises on an eligible port in IDLE.
REQ-023 In GRANT with rd_req_ack=1: ack_o[grant]=1 in the same cycle, outstanding[grant]+1, ptr=grant+1 (mod 4), return to IDLE.
REQ-024 ack_o SHALL be zero on all other ports and in all other cycles; at most one bit high per cycle.
REQ-025 In GRANT with req_i[grant]=0 (requester withdrawal): no ack, no count change, ptr unchanged, return to IDLE, err unaffected.
REQ-026 rd_req_ack while rd_req=0 SHALL be ignored and set err.
REQ-027 On rd_done: outstanding[rd_done_id]-1; if that count is 0, count stays 0 and err is set.
REQ-028 Simultaneous accept and rd_done on the same port: count unchanged; on different ports: both applied.
REQ-029 Outstanding counters SHALL be 4 bits and never wrap; an accept at MAX_OUTSTANDING cannot occur by REQ-019.
REQ-030 Minimum spacing between two accepts: 2 cycles (GRANT, IDLE); a port holding req_i gets its next burst only after the other eligible ports are served once.
REQ-031 A port remains granted until accept or withdrawal; rd_address/rd_len SHALL NOT change source mid-request.

Reset
REQ-032 With rst=1 at a clock edge: state=IDLE, grant=0, rd_id=0, ptr=0, all outstanding=0, err=0.
REQ-033 During and after reset until the next arbitration: rd_req=0, ack_o=0, busy=0.
REQ-034 Reset mid-GRANT SHALL drop rd_req the next cycle and discard counts; no ack is issued.

Verification
REQ-035 Single port: req_i=0001, len_i[0]=8'h3F, addr_i[0]=0x1000, ack 2 cycles after rd_req -> rd_req high 1 cycle after req, rd_id=0, rd_address=0x1000, rd_len=0x3F, ack_o=0001 for 1 cycle, busy=1 until rd_done with id 0.
REQ-036 All four ports request continuously, ack every GRANT cycle -> accepted rd_id sequence 0,1,2,3,0,1,... one accept every 2 cycles.
REQ-037 MAX_OUTSTANDING=4, port 2 sole requester, no rd_done -> exactly 4 accepts, then rd_req stays 0; one rd_done id 2 -> fifth accept follows.
REQ-038 Port 1 withdraws req_i while granted -> rd_req falls same cycle, no ack_o, next grant goes to the next eligible port from unchanged ptr.
REQ-039 rd_done id 3 with outstanding[3]=0 -> err=1 and stays 1 until rst; rd_req_ack with rd_req=0 -> err=1.
REQ-040 Accept and rd_done same cycle on port 0 with outstanding[0]=2 -> outstanding[0] remains 2.
